// File: rtl/alarm_clock_pkg.sv
// rtl/alarm_clock_pkg.sv - shared alarm state encoding, widths and default phase lengths
package alarm_clock_pkg;

    // Alarm FSM state codes as driven by the external alarm controller
    typedef enum logic [2:0] {
        IDLE_S      = 3'b000,
        ALARM_SET_S = 3'b001,
        IN_ALARM_S  = 3'b010,
        IN_SNOOZE_S = 3'b011
    } alarm_state_e;

    // Width of the phase seconds counter (phase lengths up to 511 s)
    localparam int unsigned REM_W = 9;

    // Default phase lengths in seconds
    localparam int unsigned DEF_ALARM_LEN_S  = 60;
    localparam int unsigned DEF_SNOOZE_LEN_S = 300;

    // Map a raw 3-bit state code onto the enum; codes 1xx fold onto IDLE
    function automatic alarm_state_e decode_state(input logic [2:0] code);
        alarm_state_e st;
        if (code[2]) begin
            st = IDLE_S;
        end else begin
            st = alarm_state_e'({1'b0, code[1:0]});
        end
        return st;
    endfunction

endpackage

// File: rtl/alarm_phase_cnt.sv
// rtl/alarm_phase_cnt.sv - loadable saturating down-counter with zero-crossing strobe
module alarm_phase_cnt
    import alarm_clock_pkg::*;
#(
    parameter int unsigned W = REM_W
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         dec_taken_o,
    output logic         zero_cross_o
);

    logic [W-1:0] count_q;
    logic         is_zero;

    // A decrement request is honoured only when no load is pending and the count is non-zero
    always_comb begin
        is_zero      = (count_q == '0);
        dec_taken_o  = dec_i & ~load_i & ~is_zero;
        zero_cross_o = dec_taken_o & (count_q == W'(1));
        count_o      = count_q;
    end

    // Count register: load has priority over decrement, zero holds until reloaded
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_taken_o) begin
            count_q <= count_q - W'(1);
        end
    end

endmodule

// File: rtl/alarm_timer.sv
// rtl/alarm_timer.sv - alarm time compare, ring/snooze phase timing and buzzer cadence
module alarm_timer
    import alarm_clock_pkg::*;
#(
    parameter int unsigned ALARM_LEN_S  = DEF_ALARM_LEN_S,
    parameter int unsigned SNOOZE_LEN_S = DEF_SNOOZE_LEN_S
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             tick_1hz_i,
    input  logic [4:0]       cur_hh_i,
    input  logic [5:0]       cur_mm_i,
    input  logic [5:0]       cur_ss_i,
    input  logic [4:0]       alarm_hh_i,
    input  logic [5:0]       alarm_mm_i,
    input  logic [2:0]       fsm_state_i,
    output logic             alarm_start_o,
    output logic             alarm_timeout_o,
    output logic             alarm_snooze_timeout_o,
    output logic             ring_o,
    output logic [REM_W-1:0] remaining_o
);

    localparam logic [REM_W-1:0] ALARM_LOAD  = REM_W'(ALARM_LEN_S);
    localparam logic [REM_W-1:0] SNOOZE_LOAD = REM_W'(SNOOZE_LEN_S);

    alarm_state_e     cur_state;
    alarm_state_e     prev_state;
    logic             entry;
    logic             in_alarm;
    logic             in_snooze;
    logic             time_match;
    logic             start_d;
    logic [REM_W-1:0] load_val;
    logic             cnt_dec;
    logic             dec_taken;
    logic             zero_cross;

    // Decode the incoming state, detect phase entry and qualify the seconds tick
    always_comb begin
        cur_state  = decode_state(fsm_state_i);
        entry      = (cur_state != prev_state);
        in_alarm   = (cur_state == IN_ALARM_S);
        in_snooze  = (cur_state == IN_SNOOZE_S);
        time_match = (cur_hh_i == alarm_hh_i) && (cur_mm_i == alarm_mm_i) && (cur_ss_i == 6'd0);
        start_d    = tick_1hz_i && (cur_state == ALARM_SET_S) && time_match;
        cnt_dec    = tick_1hz_i && !entry && (in_alarm || in_snooze);
    end

    // Length loaded on phase entry; non-timed states park the counter at zero
    always_comb begin
        load_val = '0;
        case (cur_state)
            IN_ALARM_S:  load_val = ALARM_LOAD;
            IN_SNOOZE_S: load_val = SNOOZE_LOAD;
            default:     load_val = '0;
        endcase
    end

    alarm_phase_cnt #(
        .W (REM_W)
    ) u_phase_cnt (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .load_i       (entry),
        .load_val_i   (load_val),
        .dec_i        (cnt_dec),
        .count_o      (remaining_o),
        .dec_taken_o  (dec_taken),
        .zero_cross_o (zero_cross)
    );

    // Previous-state tracking and registered one-cycle pulses
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            prev_state             <= IDLE_S;
            alarm_start_o          <= 1'b0;
            alarm_timeout_o        <= 1'b0;
            alarm_snooze_timeout_o <= 1'b0;
        end else begin
            prev_state             <= cur_state;
            alarm_start_o          <= start_d;
            alarm_timeout_o        <= zero_cross && in_alarm;
            alarm_snooze_timeout_o <= zero_cross && in_snooze;
        end
    end

    // Buzzer: on at ring entry, toggles each counted second, silent once the count hits zero
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ring_o <= 1'b0;
        end else if (entry) begin
            ring_o <= in_alarm;
        end else if (zero_cross) begin
            ring_o <= 1'b0;
        end else if (dec_taken && in_alarm) begin
            ring_o <= ~ring_o;
        end
    end

endmodule

// File: tb/tb_alarm_timer.sv
// tb/tb_alarm_timer.sv - self-checking bench for alarm_timer with randomized reference-model run
module tb_alarm_timer;

    localparam int AL = 4;
    localparam int SL = 3;

    logic       clk = 1'b0;
    logic       rst_i;
    logic       tick_1hz_i;
    logic [4:0] cur_hh_i;
    logic [5:0] cur_mm_i;
    logic [5:0] cur_ss_i;
    logic [4:0] alarm_hh_i;
    logic [5:0] alarm_mm_i;
    logic [2:0] fsm_state_i;
    logic       alarm_start_o;
    logic       alarm_timeout_o;
    logic       alarm_snooze_timeout_o;
    logic       ring_o;
    logic [8:0] remaining_o;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_prev = 0;
    int m_rem  = 0;
    bit m_ring = 0;
    bit m_start = 0;
    bit m_to = 0;
    bit m_sto = 0;

    alarm_timer #(
        .ALARM_LEN_S  (AL),
        .SNOOZE_LEN_S (SL)
    ) dut (
        .clk_i                  (clk),
        .rst_i                  (rst_i),
        .tick_1hz_i             (tick_1hz_i),
        .cur_hh_i               (cur_hh_i),
        .cur_mm_i               (cur_mm_i),
        .cur_ss_i               (cur_ss_i),
        .alarm_hh_i             (alarm_hh_i),
        .alarm_mm_i             (alarm_mm_i),
        .fsm_state_i            (fsm_state_i),
        .alarm_start_o          (alarm_start_o),
        .alarm_timeout_o        (alarm_timeout_o),
        .alarm_snooze_timeout_o (alarm_snooze_timeout_o),
        .ring_o                 (ring_o),
        .remaining_o            (remaining_o)
    );

    always #5 clk = ~clk;

    // Advance one clock: apply the behavioural rules to the current inputs, then sample after the edge
    task automatic step();
        int st;
        st = fsm_state_i[2] ? 0 : int'(fsm_state_i);
        m_start = 0;
        m_to    = 0;
        m_sto   = 0;
        if (rst_i) begin
            m_rem  = 0;
            m_ring = 0;
            m_prev = 0;
        end else begin
            m_start = tick_1hz_i && st == 1 && cur_hh_i == alarm_hh_i
                      && cur_mm_i == alarm_mm_i && cur_ss_i == 0;
            if (st != m_prev) begin
                m_rem  = (st == 2) ? AL : (st == 3) ? SL : 0;
                m_ring = (st == 2);
            end else if (tick_1hz_i && (st == 2 || st == 3) && m_rem > 0) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_ring = 0;
                    if (st == 2) m_to = 1; else m_sto = 1;
                end else if (st == 2) begin
                    m_ring = !m_ring;
                end
            end
            m_prev = st;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc(input logic t);
        tick_1hz_i = t;
        step();
        tick_1hz_i = 1'b0;
    endtask

    task automatic set_time(input int hh, input int mm, input int ss);
        cur_hh_i = 5'(hh);
        cur_mm_i = 6'(mm);
        cur_ss_i = 6'(ss);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        cyc(1'b1);
        cyc(1'b0);
        n_tests++;
        if ({alarm_start_o, alarm_timeout_o, alarm_snooze_timeout_o, ring_o} !== 4'b0
            || remaining_o !== 9'd0) begin
            n_fail++;
            $display("FAIL reset: pulses/ring=%b rem=%0d, expected 0000 rem=0",
                     {alarm_start_o, alarm_timeout_o, alarm_snooze_timeout_o, ring_o}, remaining_o);
        end
        rst_i = 1'b0;
        cyc(1'b0);
    endtask

    task automatic test_alarm_start();
        fsm_state_i = 3'b001;
        alarm_hh_i  = 5'd7;
        alarm_mm_i  = 6'd30;
        set_time(7, 29, 59);
        cyc(1'b1);
        n_tests++;
        if (alarm_start_o !== 1'b0) begin
            n_fail++;
            $display("FAIL start_early: alarm_start_o=%b expected 0", alarm_start_o);
        end
        set_time(7, 30, 0);
        cyc(1'b1);
        n_tests++;
        if (alarm_start_o !== 1'b1) begin
            n_fail++;
            $display("FAIL start_match: alarm_start_o=%b expected 1", alarm_start_o);
        end
        set_time(7, 30, 1);
        cyc(1'b1);
        n_tests++;
        if (alarm_start_o !== 1'b0) begin
            n_fail++;
            $display("FAIL start_after: alarm_start_o=%b expected 0", alarm_start_o);
        end
    endtask

    task automatic test_idle_no_start();
        fsm_state_i = 3'b000;
        cyc(1'b0);
        set_time(7, 30, 0);
        cyc(1'b1);
        n_tests++;
        if (alarm_start_o !== 1'b0 || remaining_o !== 9'd0) begin
            n_fail++;
            $display("FAIL idle_no_start: start=%b rem=%0d expected start=0 rem=0",
                     alarm_start_o, remaining_o);
        end
    endtask

    task automatic test_alarm_ring();
        int exp_rem[4]  = '{3, 2, 1, 0};
        bit exp_ring[4] = '{0, 1, 0, 0};
        bit exp_to[4]   = '{0, 0, 0, 1};
        set_time(8, 0, 0);
        fsm_state_i = 3'b010;
        cyc(1'b0);
        n_tests++;
        if (remaining_o !== 9'(AL) || ring_o !== 1'b1) begin
            n_fail++;
            $display("FAIL ring_entry: rem=%0d ring=%b expected rem=%0d ring=1", remaining_o, ring_o, AL);
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1);
            n_tests++;
            if (remaining_o !== 9'(exp_rem[i]) || ring_o !== exp_ring[i]
                || alarm_timeout_o !== exp_to[i] || alarm_snooze_timeout_o !== 1'b0) begin
                n_fail++;
                $display("FAIL ring_tick%0d: rem=%0d ring=%b to=%b sto=%b expected rem=%0d ring=%b to=%b sto=0",
                         i, remaining_o, ring_o, alarm_timeout_o, alarm_snooze_timeout_o,
                         exp_rem[i], exp_ring[i], exp_to[i]);
            end
        end
        cyc(1'b1);
        n_tests++;
        if (remaining_o !== 9'd0 || ring_o !== 1'b0 || alarm_timeout_o !== 1'b0) begin
            n_fail++;
            $display("FAIL ring_saturate: rem=%0d ring=%b to=%b expected 0 0 0",
                     remaining_o, ring_o, alarm_timeout_o);
        end
    endtask

    task automatic test_snooze();
        fsm_state_i = 3'b011;
        cyc(1'b1);
        n_tests++;
        if (remaining_o !== 9'(SL) || ring_o !== 1'b0 || alarm_snooze_timeout_o !== 1'b0) begin
            n_fail++;
            $display("FAIL snooze_entry_tick: rem=%0d ring=%b sto=%b expected rem=%0d ring=0 sto=0",
                     remaining_o, ring_o, alarm_snooze_timeout_o, SL);
        end
        for (int i = 1; i <= SL + 2; i++) begin
            cyc(1'b1);
            n_tests++;
            if (remaining_o !== 9'((i >= SL) ? 0 : SL - i)
                || alarm_snooze_timeout_o !== (i == SL)
                || alarm_timeout_o !== 1'b0 || ring_o !== 1'b0) begin
                n_fail++;
                $display("FAIL snooze_tick%0d: rem=%0d sto=%b to=%b ring=%b expected rem=%0d sto=%b to=0 ring=0",
                         i, remaining_o, alarm_snooze_timeout_o, alarm_timeout_o, ring_o,
                         (i >= SL) ? 0 : SL - i, (i == SL));
            end
        end
    endtask

    task automatic test_reset_mid();
        fsm_state_i = 3'b000;
        cyc(1'b0);
        fsm_state_i = 3'b010;
        cyc(1'b0);
        cyc(1'b1);
        cyc(1'b1);
        n_tests++;
        if (remaining_o !== 9'd2) begin
            n_fail++;
            $display("FAIL reset_mid_pre: rem=%0d expected 2", remaining_o);
        end
        rst_i = 1'b1;
        cyc(1'b1);
        n_tests++;
        if (remaining_o !== 9'd0 || ring_o !== 1'b0 || alarm_timeout_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid: rem=%0d ring=%b to=%b expected 0 0 0",
                     remaining_o, ring_o, alarm_timeout_o);
        end
        rst_i = 1'b0;
        cyc(1'b1);
        n_tests++;
        if (remaining_o !== 9'(AL) || ring_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_reentry: rem=%0d ring=%b expected rem=%0d ring=1", remaining_o, ring_o, AL);
        end
    endtask

    task automatic test_unknown_state();
        fsm_state_i = 3'b110;
        cyc(1'b1);
        n_tests++;
        if (remaining_o !== 9'd0 || ring_o !== 1'b0 || alarm_timeout_o !== 1'b0) begin
            n_fail++;
            $display("FAIL unknown_as_idle: rem=%0d ring=%b to=%b expected 0 0 0",
                     remaining_o, ring_o, alarm_timeout_o);
        end
        fsm_state_i = 3'b010;
        cyc(1'b0);
        fsm_state_i = 3'b101;
        cyc(1'b0);
        n_tests++;
        if (remaining_o !== 9'd0 || ring_o !== 1'b0) begin
            n_fail++;
            $display("FAIL unknown_entry: rem=%0d ring=%b expected 0 0", remaining_o, ring_o);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 5) == 0) fsm_state_i = 3'($urandom_range(0, 7));
            tick_1hz_i = ($urandom_range(0, 1) == 1);
            rst_i      = ($urandom_range(0, 60) == 0);
            if ($urandom_range(0, 2) == 0) begin
                set_time(int'(alarm_hh_i), int'(alarm_mm_i), ($urandom_range(0, 1) == 1) ? 0 : 1);
            end else begin
                set_time($urandom_range(0, 23), $urandom_range(0, 59), $urandom_range(0, 59));
            end
            if ($urandom_range(0, 50) == 0) begin
                alarm_hh_i = 5'($urandom_range(0, 23));
                alarm_mm_i = 6'($urandom_range(0, 59));
            end
            step();
            n_tests++;
            if (remaining_o !== 9'(m_rem) || ring_o !== m_ring || alarm_start_o !== m_start
                || alarm_timeout_o !== m_to || alarm_snooze_timeout_o !== m_sto) begin
                n_fail++;
                $display("FAIL random%0d: rem=%0d ring=%b start=%b to=%b sto=%b expected rem=%0d ring=%b start=%b to=%b sto=%b",
                         i, remaining_o, ring_o, alarm_start_o, alarm_timeout_o, alarm_snooze_timeout_o,
                         m_rem, m_ring, m_start, m_to, m_sto);
            end
        end
        rst_i      = 1'b0;
        tick_1hz_i = 1'b0;
    endtask

    initial begin
        rst_i       = 1'b1;
        tick_1hz_i  = 1'b0;
        fsm_state_i = 3'b000;
        alarm_hh_i  = 5'd0;
        alarm_mm_i  = 6'd0;
        set_time(0, 0, 0);
        #2;
        test_reset();
        test_alarm_start();
        test_idle_no_start();
        test_alarm_ring();
        test_snooze();
        test_reset_mid();
        test_unknown_state();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
